conv_rowpair_pool_relu: RTL and testbench
=========================================

# conv_rowpair_pool_relu

Streaming 2x2 max-pool plus ReLU stage that sits directly after a convolution engine. It accepts one signed pixel per valid cycle, row-major, for a feature map W pixels wide. Every pair of rows produces W/2 pooled, rectified outputs, emitted during the second row of the pair. There is no backpressure.

## Interface
- In_d_W, default 32: data width of input and output samples, two's-complement signed.
- W, default 26: row width in pixels. Must be at least 2. If odd, the last column of each row is dropped.
- clk, input, 1 bit: single clock; all state updates on its rising edge.
- clr, input, 1 bit: reset, asynchronous and active-high.
- in_valid, input, 1 bit: qualifies in_data; one pixel is accepted per cycle when high.
- in_data, input, signed In_d_W bits: input pixel.
- out_valid, output, 1 bit: one-cycle pulse marking a pooled result.
- out_data, output, signed In_d_W bits: pooled, ReLU'd result. Holds its last value when out_valid is low.

## Operation
- State:
  - col counter, 0..W-1.
  - row parity bit: 0 = first row of pair, 1 = second row.
  - pixel hold register.
  - line buffer of floor(W/2) entries, each In_d_W bits.
- Pixel index: an accepted pixel (in_valid=1) has index col. col increments on each accepted pixel. After index W-1, col wraps to 0 and row parity toggles. Cycles with in_valid=0 change nothing.
- First row of pair (parity 0):
  - Even col: store the pixel in the hold register.
  - Odd col 2k+1: write max(hold, pixel) into line buffer entry k.
- Second row of pair (parity 1):
  - Even col: store the pixel in the hold register.
  - Odd col 2k+1: compute m = max(hold, pixel, linebuf[k]).
  - Register out_data = (m < 0) ? 0 : m and assert out_valid for one cycle.
- All comparisons are signed, full width, with no saturation or truncation. ReLU maps negatives to 0 and passes 0 and positives unchanged.
- Odd W: the pixel at col W-1 is accepted and counted but never pooled.
- Output order: k = 0..floor(W/2)-1, left to right, once per row pair.
- Outputs per row pair: floor(W/2). With W=26 that is 13, so 4 rows give 26 outputs.
- Rows may be separated by any number of idle cycles. Gaps inside a row are also allowed; pooling is unaffected.
- Reset (clr=1, async):
  - out_valid=0, out_data=0.
  - col=0, parity=0, hold=0.
  - Line buffer contents need not be cleared; they are always rewritten before use.
- Reset mid-row or mid-pair discards partial data. The next accepted pixel is treated as col 0 of a first row.

## Timing
- Latency: out_valid rises on the clock edge that accepts the odd-column pixel 2k+1 of the second row. It is visible the cycle after that pixel is driven, so latency is 1 cycle.
- Output rate: with continuous in_valid in the second row, out_valid pulses every other cycle. The pattern is 0,1,0,1,... relative to input cycles, shifted by 1.
- During the first row of a pair, out_valid stays 0.
- After the final accepted pixel of a pair, at most one more out_valid pulse occurs; the stream is then quiet.
- No combinational path from inputs to outputs.
- Line buffer: a write (first row) and a read (second row) never target the same row pair simultaneously, so no bypass is required.

## Test plan
- Ramp, W=26: row 1 = 0..25, row 2 = 100..125, back to back -> 13 outputs: 101, 103, ..., 125. Each appears 1 cycle after the odd-column pixel is accepted, every other cycle.
- All-negative pair: rows of -10..-1 repeated -> 13 outputs, all 0. A pair containing a single 0 yields 0; a pair with one +3 yields 3.
- Max position sweep: for each k, place 7 at one of the four window positions, with -5 elsewhere -> output k = 7 and all others 0. Checks that every window position participates.
- Gapped input: insert random in_valid=0 cycles inside and between rows of the ramp test -> identical output values and count. out_valid follows the accepting edge of each odd second-row pixel.
- Reset mid-operation: assert clr asynchronously (not edge-aligned) halfway through row 2 -> out_valid=0 and out_data=0 immediately. Then a fresh 4-row stream gives exactly 26 correct outputs.
- Random 4-row stream with values -10..10, W=26 -> exactly 26 outputs, each matching a reference model of max(2x2) then ReLU. No out_valid during rows 1 and 3. Additionally run W=5 -> 2 outputs per pair, with col 4 ignored.

Source files
------------

// File: rtl/conv_rowpair_pool_relu.sv
// Streaming 2x2 max-pool followed by ReLU.
// Pixels arrive row-major, one per in_valid cycle, for a map W pixels wide.
// On the first row of each pair, horizontal pair maxima go into a line buffer.
// On the second row, each horizontal pair max is combined with the matching
// line-buffer entry. The rectified result is registered and marked with a
// one-cycle out_valid pulse. An odd trailing column is counted but never pooled.
module conv_rowpair_pool_relu #(
  parameter int In_d_W = 32,
  parameter int W      = 26
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic signed [In_d_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [In_d_W-1:0] out_data
);

  localparam int NPOOL = W / 2;
  localparam int COL_W = $clog2(W);
  localparam int K_W   = (NPOOL > 1) ? $clog2(NPOOL) : 1;

  logic [COL_W-1:0]         col;
  logic                     parity;
  logic signed [In_d_W-1:0] hold;
  logic signed [In_d_W-1:0] linebuf [NPOOL];

  logic [K_W-1:0]           k_idx;
  logic                     odd_col;
  logic                     last_col;
  logic signed [In_d_W-1:0] pair_max;
  logic signed [In_d_W-1:0] lb_rd;
  logic signed [In_d_W-1:0] window_max;
  logic signed [In_d_W-1:0] relu_val;

  // Window decode and datapath: pair max, 2x2 max and rectification.
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    k_idx      = K_W'(col >> 1);
    odd_col    = col[0];
    last_col   = (col == COL_W'(W - 1));
    pair_max   = (hold > in_data) ? hold : in_data;
    lb_rd      = linebuf[k_idx];
    window_max = (pair_max > lb_rd) ? pair_max : lb_rd;
    relu_val   = window_max[In_d_W-1] ? '0 : window_max;
  end

  // Column counter, row parity and even-column hold register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      col    <= '0;
      parity <= 1'b0;
      hold   <= '0;
    end else if (in_valid) begin
      if (!odd_col) begin
        hold <= in_data;
      end
      if (last_col) begin
        col    <= '0;
        parity <= ~parity;
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Line buffer: pair maxima of the first row of each pair.
  // NOTE: the line buffer is deliberately not reset; every entry is written
  // during the first row before the second row reads it, and leaving it out
  // of reset lets it map onto plain storage.
  always_ff @(posedge clk) begin
    if (in_valid && !parity && odd_col) begin
      linebuf[k_idx] <= pair_max;
    end
  end

  // Registered output: pulse on each odd second-row pixel, hold data otherwise.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid && parity && odd_col) begin
        out_valid <= 1'b1;
        out_data  <= relu_val;
      end
    end
  end

endmodule

// File: tb/tb_conv_rowpair_pool_relu.sv
// Self-checking bench for conv_rowpair_pool_relu.
// Two instances: W=26 (main) and W=5 (odd width). The reference model stores
// the pixels of each row pair in plain arrays. At every odd column of a second
// row it takes the max of the 2x2 window, then applies ReLU.
module tb_conv_rowpair_pool_relu;

  localparam int DW = 32;

  logic                 clk;
  logic                 clr;
  logic                 v0, v1;
  logic signed [DW-1:0] d0, d1;
  logic                 ov0, ov1;
  logic signed [DW-1:0] od0, od1;

  int total;
  int bad;

  // Reference model state, index 0 = W26 instance, 1 = W5 instance.
  int wdt    [2];
  int col_m  [2];
  int par_m  [2];
  int pulses [2];
  int exp_n  [2];
  int row0_m [2][26];
  int row1_m [2][26];
  int last_m [2];

  conv_rowpair_pool_relu #(.In_d_W(DW), .W(26)) dut_w26 (
    .clk      (clk),
    .clr      (clr),
    .in_valid (v0),
    .in_data  (d0),
    .out_valid(ov0),
    .out_data (od0)
  );

  conv_rowpair_pool_relu #(.In_d_W(DW), .W(5)) dut_w5 (
    .clk      (clk),
    .clr      (clr),
    .in_valid (v1),
    .in_data  (d1),
    .out_valid(ov1),
    .out_data (od1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      col_m[s]  = 0;
      par_m[s]  = 0;
      last_m[s] = 0;
    end
  endtask

  task automatic check(input int s, input logic ev, input int ed, input string tag);
    logic                 ov;
    logic signed [DW-1:0] od;
    logic signed [DW-1:0] edv;
    ov  = (s == 0) ? ov0 : ov1;
    od  = (s == 0) ? od0 : od1;
    edv = ed;
    if (ov === 1'b1) pulses[s]++;
    total++;
    assert (ov === ev) else begin
      bad++;
      $error("FAIL %s[w%0d] out_valid observed=%0b expected=%0b", tag, wdt[s], ov, ev);
    end
    total++;
    assert (od === edv) else begin
      bad++;
      $error("FAIL %s[w%0d] out_data observed=%0d expected=%0d", tag, wdt[s], od, edv);
    end
  endtask

  task automatic count_check(input int s, input int expected, input string tag);
    total++;
    assert (pulses[s] === expected) else begin
      bad++;
      $error("FAIL %s[w%0d] pulse count observed=%0d expected=%0d", tag, wdt[s], pulses[s], expected);
    end
  endtask

  // Drive one pixel into instance s, then check both instances after the edge.
  task automatic send(input int s, input int v);
    logic ev;
    int   c;
    int   m;
    @(negedge clk);
    if (s == 0) begin v0 = 1'b1; d0 = v; end
    else        begin v1 = 1'b1; d1 = v; end
    c  = col_m[s];
    ev = 1'b0;
    if (par_m[s] == 0) row0_m[s][c] = v;
    else               row1_m[s][c] = v;
    if (par_m[s] == 1 && (c % 2) == 1 && c < 2 * (wdt[s] / 2)) begin
      m = max2(max2(row0_m[s][c-1], row0_m[s][c]), max2(row1_m[s][c-1], row1_m[s][c]));
      last_m[s] = (m < 0) ? 0 : m;
      ev = 1'b1;
      exp_n[s]++;
    end
    if (c == wdt[s] - 1) begin
      col_m[s] = 0;
      par_m[s] = 1 - par_m[s];
    end else begin
      col_m[s] = c + 1;
    end
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
    check(s, ev, last_m[s], "pix");
    check(1 - s, 1'b0, last_m[1 - s], "quiet");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      v0 = 1'b0;
      v1 = 1'b0;
      @(posedge clk);
      #1;
      check(0, 1'b0, last_m[0], "idle");
      check(1, 1'b0, last_m[1], "idle");
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    wdt[0] = 26;
    wdt[1] = 5;
    pulses = '{0, 0};
    exp_n  = '{0, 0};
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
    model_reset();

    // Reset state
    clr = 1'b1;
    #1;
    check(0, 1'b0, 0, "reset");
    check(1, 1'b0, 0, "reset");
    @(negedge clk);
    clr = 1'b0;
    idle(2);

    // Ramp pair: 0..25 then 100..125 gives 101,103,...,125
    for (int i = 0; i < 26; i++) send(0, i);
    for (int i = 0; i < 26; i++) send(0, 100 + i);
    total++;
    assert (od0 === 32'sd125) else begin
      bad++;
      $error("FAIL ramp_last out_data observed=%0d expected=125", od0);
    end
    idle(2);

    // All-negative pair -> all zero
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 26; i++) send(0, -10 + (i % 10));
    // Pair with a single 0, then a pair with a single +3
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 26; i++) send(0, (r == 0 && i == 7) ? 0 : -5);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 26; i++) send(0, (r == 1 && i == 20) ? 3 : -5);
    total++;
    assert (od0 === 32'sd0) else begin
      bad++;
      $error("FAIL plus3_tail out_data observed=%0d expected=0", od0);
    end

    // Max position sweep: 7 at each window position of each k
    for (int k = 0; k < 13; k++)
      for (int p = 0; p < 4; p++)
        for (int r = 0; r < 2; r++)
          for (int i = 0; i < 26; i++)
            send(0, (r == p / 2 && i == 2 * k + (p % 2)) ? 7 : -5);

    // Gapped ramp: random idles inside and between rows
    pulses[0] = 0;
    exp_n[0]  = 0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 26; i++) begin
        if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(3, 1)));
        send(0, (r == 0) ? i : 100 + i);
      end
      idle(int'($urandom_range(5, 0)));
    end
    count_check(0, 13, "gapped");

    // Asynchronous reset halfway through the second row
    for (int i = 0; i < 26; i++) send(0, int'($urandom_range(20, 0)) - 10);
    for (int i = 0; i < 13; i++) send(0, int'($urandom_range(20, 0)) - 10);
    @(negedge clk);
    #2 clr = 1'b1;
    model_reset();
    #1;
    check(0, 1'b0, 0, "midreset");
    check(1, 1'b0, 0, "midreset");
    @(negedge clk);
    clr = 1'b0;

    // Fresh random 4-row stream, W=26 -> 26 outputs
    pulses[0] = 0;
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 26; i++) send(0, int'($urandom_range(20, 0)) - 10);
    count_check(0, 26, "rand26");

    // Odd width W=5: 2 outputs per pair, col 4 ignored
    pulses[1] = 0;
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 5; i++)
        send(1, (i == 4) ? 50 : int'($urandom_range(20, 0)) - 10);
    count_check(1, 4, "rand5");
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
